mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port, synchronous-read data memory. It shares the memory between an instruction-fetch port (read-only) and a data load/store port (read/write). It converts per-port request/grant handshakes into correctly timed memory cycles and returns read data with a response-valid pulse. It sits between the core's fetch/LSU logic and the memory instance.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Port bundle for mem_arbiter: fetch port, data port and the memory-side bus.
// slave is the arbiter's view; master is the view of whatever drives requests and models memory.
interface mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a single-port synchronous-read memory.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise the data port has fixed priority.
module mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              grant;
  logic              pick_data;
  logic              data_prio;
  logic              cur_data;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Handshake: a port holds req (with its command) until it sees a one-cycle gnt;
  // gnt is only given in IDLE, and a read completes later with a one-cycle rvalid.
`ifdef MEM_ARB_RR_EN
  logic last_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_data <= 1'b1;
    end else if (grant) begin
      last_data <= pick_data;
    end
  end

  assign data_prio = ~last_data;
`else
  assign data_prio = 1'b1;
`endif

  assign pick_data = bus.d_req && (!bus.if_req || data_prio);
  assign sel_addr  = pick_data ? bus.d_addr : bus.if_addr;
  assign sel_wdata = pick_data ? bus.d_wdata : '0;
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    bus.if_gnt = 1'b0;
    bus.d_gnt  = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (bus.if_req || bus.d_req)) begin
          grant      = 1'b1;
          bus.d_gnt  = pick_data;
          bus.if_gnt = !pick_data;
          state_next = ISSUE;
        end
      end
      // mem_we is only ever high here for a write, so it doubles as the write flag.
      ISSUE:   state_next = bus.mem_we ? IDLE : WAIT;
      WAIT:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cur_data      <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
    end else begin
      state         <= state_next;
      bus.mem_we    <= grant && pick_data && bus.d_we;
      bus.if_rvalid <= (state == WAIT) && !cur_data;
      bus.d_rvalid  <= (state == WAIT) && cur_data;
      if (grant) begin
        bus.mem_addr  <= sel_addr;
        bus.mem_wdata <= sel_wdata;
        cur_data      <= pick_data;
      end
      if (state == WAIT) begin
        if (cur_data) begin
          bus.d_rdata <= bus.mem_rdata;
        end else begin
          bus.if_rdata <= bus.mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 512-word memory (word i resets to i).
// Contention expectations follow MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  int d_gnt_cnt = 0;
  int if_rv_cnt = 0;
  int base_cnt;
  logic [31:0] exp_q[$];
  logic [31:0] exp_port;

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- memory model ----------------
  logic [DATA_W-1:0] mem [512];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) mem[i] <= DATA_W'(i);
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  // ---------------- event monitors ----------------
  always @(negedge clk) begin
    if (bus.d_gnt) d_gnt_cnt <= d_gnt_cnt + 1;
    if (bus.if_rvalid) if_rv_cnt <= if_rv_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {27'd0, bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid, bus.mem_we};
  endfunction

  function automatic logic [31:0] gnt_pair();
    return {30'd0, bus.if_gnt, bus.d_gnt};
  endfunction

  function automatic logic [31:0] rv_pair();
    return {30'd0, bus.if_rvalid, bus.d_rvalid};
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_flags"}, flags(), 32'd0);
    check_eq({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
    check_eq({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
    check_eq({tag, "_d_rdata"}, bus.d_rdata, 32'd0);
    check_eq({tag, "_mem_addr"}, {23'd0, bus.mem_addr}, 32'd0);
    check_eq({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    // Reset state, including a request that must not be granted while rst is high.
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    bus.if_req = 1'b1;
    #1;
    check_eq("reset_no_gnt", gnt_pair(), 32'd0);
    bus.if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Fetch read of address 5, no contention.
    tick();
    bus.if_req = 1'b1; bus.if_addr = 9'd5;
    #1;
    check_eq("f_gnt", gnt_pair(), 32'd2);
    tick();
    bus.if_req = 1'b0;
    #1;
    check_eq("f_issue_state", {30'd0, dbg_state}, 32'd1);
    check_eq("f_mem_addr", {23'd0, bus.mem_addr}, 32'd5);
    check_eq("f_mem_we", {31'd0, bus.mem_we}, 32'd0);
    tick(); #1;
    check_eq("f_wait_rv", rv_pair(), 32'd0);
    tick(); #1;
    check_eq("f_rvalid", rv_pair(), 32'd2);
    check_eq("f_rdata", bus.if_rdata, 32'd5);
    tick(); #1;
    check_eq("f_rv_drop", rv_pair(), 32'd0);
    check_eq("f_idle", {30'd0, dbg_state}, 32'd0);

    // Data write of 0xDEADBEEF to address 10, then read it back.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 9'd10; bus.d_wdata = 32'hDEADBEEF;
    #1;
    check_eq("w_gnt", gnt_pair(), 32'd1);
    tick();
    bus.d_req = 1'b0;
    #1;
    check_eq("w_mem_we", {31'd0, bus.mem_we}, 32'd1);
    check_eq("w_mem_addr", {23'd0, bus.mem_addr}, 32'd10);
    check_eq("w_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    tick(); #1;
    check_eq("w_we_drop", {31'd0, bus.mem_we}, 32'd0);
    check_eq("w_idle", {30'd0, dbg_state}, 32'd0);
    check_eq("w_no_rv", rv_pair(), 32'd0);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 9'd10;
    #1;
    check_eq("r_gnt", gnt_pair(), 32'd1);
    tick();
    bus.d_req = 1'b0;
    #1;
    check_eq("r_mem_we", {31'd0, bus.mem_we}, 32'd0);
    tick(); #1;
    check_eq("r_wait_rv", rv_pair(), 32'd0);
    tick(); #1;
    check_eq("r_rvalid", rv_pair(), 32'd1);
    check_eq("r_rdata", bus.d_rdata, 32'hDEADBEEF);
    tick(); #1;

    // Contention: both ports read continuously; 1 = data winner, 0 = fetch winner.
`ifdef MEM_ARB_RR_EN
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
`else
    exp_q = '{32'd1, 32'd1, 32'd1, 32'd1};
`endif
    bus.if_req = 1'b1; bus.if_addr = 9'd20;
    bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 9'd30;
    #1;
    while (exp_q.size() > 0) begin
      exp_port = exp_q.pop_front();
      check_eq("c_gnt", gnt_pair(), exp_port[0] ? 32'd1 : 32'd2);
      tick(); #1;
      check_eq("c_busy_gnt", gnt_pair(), 32'd0);
      tick(); #1;
      tick(); #1;
      check_eq("c_rvalid", rv_pair(), exp_port[0] ? 32'd1 : 32'd2);
      check_eq("c_rdata", exp_port[0] ? bus.d_rdata : bus.if_rdata,
               exp_port[0] ? 32'd30 : 32'd20);
      tick(); #1;
    end
    bus.d_req = 1'b0;
    #1;
    check_eq("c_drop_gnt", gnt_pair(), 32'd2);
    tick();
    bus.if_req = 1'b0;
    tick(); #1;
    tick(); #1;
    check_eq("c_drop_rvalid", rv_pair(), 32'd2);
    check_eq("c_drop_rdata", bus.if_rdata, 32'd20);
    tick(); #1;

    // Busy hold-off: data request raised in the ISSUE cycle of a fetch read.
    bus.if_req = 1'b1; bus.if_addr = 9'd7;
    #1;
    check_eq("h_f_gnt", gnt_pair(), 32'd2);
    base_cnt = d_gnt_cnt;
    tick();
    bus.if_req = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 9'd3;
    #1;
    check_eq("h_issue_gnt", gnt_pair(), 32'd0);
    tick(); #1;
    check_eq("h_wait_gnt", gnt_pair(), 32'd0);
    tick(); #1;
    check_eq("h_resp_gnt", gnt_pair(), 32'd0);
    check_eq("h_f_rvalid", rv_pair(), 32'd2);
    check_eq("h_f_rdata", bus.if_rdata, 32'd7);
    tick(); #1;
    check_eq("h_d_gnt", gnt_pair(), 32'd1);
    tick();
    bus.d_req = 1'b0;
    tick(); #1;
    tick(); #1;
    check_eq("h_d_rvalid", rv_pair(), 32'd1);
    check_eq("h_d_rdata", bus.d_rdata, 32'd3);
    tick(); tick(); #1;
    check_eq("h_gnt_count", 32'(d_gnt_cnt - base_cnt), 32'd1);

    // Reset during WAIT of a fetch read.
    bus.if_req = 1'b1; bus.if_addr = 9'd9;
    #1;
    check_eq("x_gnt", gnt_pair(), 32'd2);
    tick();
    bus.if_req = 1'b0;
    tick(); #1;
    check_eq("x_wait_state", {30'd0, dbg_state}, 32'd2);
    base_cnt = if_rv_cnt;
    rst = 1'b1;
    #1;
    check_all_zero("x_reset");
    tick(); tick();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick();
    #1;
    check_eq("x_no_rvalid", 32'(if_rv_cnt - base_cnt), 32'd0);
    bus.if_req = 1'b1; bus.if_addr = 9'd11;
    bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 9'd12;
    #1;
`ifdef MEM_ARB_RR_EN
    check_eq("x_post_gnt", gnt_pair(), 32'd2);
`else
    check_eq("x_post_gnt", gnt_pair(), 32'd1);
`endif
    tick();
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick(); #1;
    tick(); #1;
`ifdef MEM_ARB_RR_EN
    check_eq("x_post_rvalid", rv_pair(), 32'd2);
    check_eq("x_post_rdata", bus.if_rdata, 32'd11);
`else
    check_eq("x_post_rvalid", rv_pair(), 32'd1);
    check_eq("x_post_rdata", bus.d_rdata, 32'd12);
`endif
    tick(); #1;

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
